// File: rtl/line_judge_pkg.sv
// Shared types and direction helpers for the line_judge end-of-game judge.
package line_judge_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;

  localparam int NUM_DIRS = 4;

  // Row step per stone for each direction (H, V, D, A)
  function automatic int dir_dr(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int dir_dc(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 1;
      default: return -1;
    endcase
  endfunction

  // Lowest set bit wins, giving the H, V, D, A tie-break order
  function automatic dir_t first_dir(input logic [NUM_DIRS-1:0] hit);
    if (hit[0])      return DIR_H;
    else if (hit[1]) return DIR_V;
    else if (hit[2]) return DIR_D;
    else             return DIR_A;
  endfunction

endpackage

// File: rtl/judge_cell_lines.sv
// Combinational check of the four lines starting at one cell of one board.
module judge_cell_lines
  import line_judge_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [ROWS*COLS-1:0] board,
  input  logic [RW-1:0]        r,
  input  logic [CW-1:0]        c,
  output logic [NUM_DIRS-1:0]  hit
);

  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  int            rr;
  int            cc;
  logic          ok;
  logic [IW-1:0] idx;

  // A line only counts when every one of its cells lies on the board
  always_comb begin
    hit = '0;
    rr  = 0;
    cc  = 0;
    ok  = 1'b0;
    idx = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      ok = 1'b1;
      for (int k = 0; k < WIN_LEN; k++) begin
        rr = int'(r) + k * dir_dr(d);
        cc = int'(c) + k * dir_dc(d);
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
          ok = 1'b0;
        end else begin
          idx = IW'(rr * COLS + cc);
          if (!board[idx]) ok = 1'b0;
        end
      end
      hit[d] = ok;
    end
  end

endmodule

// File: rtl/line_judge.sv
// Sequential end-of-game judge: scans one cell per cycle, reports first win, draw or illegal board.
module line_judge
  import line_judge_pkg::*;
#(
  parameter int ROWS    = 3,
  parameter int COLS    = 3,
  parameter int WIN_LEN = 3,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  output logic                 ready,
  input  logic [ROWS*COLS-1:0] board_a,
  input  logic [ROWS*COLS-1:0] board_b,
  output logic                 valid,
  output logic                 end_of_game,
  output logic                 win_a,
  output logic                 win_b,
  output logic                 draw,
  output logic                 illegal,
  output logic [RW-1:0]        win_row,
  output logic [CW-1:0]        win_col,
  output logic [1:0]           win_dir
);

  state_t                state, next_state;
  logic                  busy;
  logic                  accept;
  logic                  last_cell;
  logic [ROWS*COLS-1:0]  cap_a, cap_b;
  logic [RW-1:0]         r;
  logic [CW-1:0]         c;
  logic [NUM_DIRS-1:0]   hit_a, hit_b;
  logic                  found_a, found_b;
  logic [RW-1:0]         row_a, row_b;
  logic [CW-1:0]         col_a, col_b;
  dir_t                  dir_a, dir_b;
  logic                  overlap, full, both_win;

  judge_cell_lines #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_lines_a (
    .board (cap_a),
    .r     (r),
    .c     (c),
    .hit   (hit_a)
  );

  judge_cell_lines #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_lines_b (
    .board (cap_b),
    .r     (r),
    .c     (c),
    .hit   (hit_b)
  );

  assign ready     = !req && !busy;
  assign overlap   = |(cap_a & cap_b);
  assign full      = &(cap_a | cap_b);
  assign both_win  = found_a & found_b;
  assign last_cell = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req && !busy) begin
          accept     = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN:    if (last_cell) next_state = EMIT;
      EMIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture, cursor walk, first-hit bookkeeping and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b1;
      cap_a       <= '0;
      cap_b       <= '0;
      r           <= '0;
      c           <= '0;
      found_a     <= 1'b0;
      found_b     <= 1'b0;
      row_a       <= '0;
      row_b       <= '0;
      col_a       <= '0;
      col_b       <= '0;
      dir_a       <= DIR_H;
      dir_b       <= DIR_H;
      valid       <= 1'b0;
      end_of_game <= 1'b0;
      win_a       <= 1'b0;
      win_b       <= 1'b0;
      draw        <= 1'b0;
      illegal     <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      win_dir     <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (accept) begin
            busy        <= 1'b1;
            cap_a       <= board_a;
            cap_b       <= board_b;
            r           <= '0;
            c           <= '0;
            found_a     <= 1'b0;
            found_b     <= 1'b0;
            row_a       <= '0;
            row_b       <= '0;
            col_a       <= '0;
            col_b       <= '0;
            dir_a       <= DIR_H;
            dir_b       <= DIR_H;
            end_of_game <= 1'b0;
            win_a       <= 1'b0;
            win_b       <= 1'b0;
            draw        <= 1'b0;
            illegal     <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            win_dir     <= '0;
          end else if (!req) begin
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if ((hit_a != '0) && !found_a) begin
            found_a <= 1'b1;
            row_a   <= r;
            col_a   <= c;
            dir_a   <= first_dir(hit_a);
          end
          if ((hit_b != '0) && !found_b) begin
            found_b <= 1'b1;
            row_b   <= r;
            col_b   <= c;
            dir_b   <= first_dir(hit_b);
          end
          if (c == CW'(COLS - 1)) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        EMIT: begin
          win_a       <= found_a;
          win_b       <= found_b;
          illegal     <= overlap | both_win;
          draw        <= full & ~found_a & ~found_b & ~(overlap | both_win);
          end_of_game <= found_a | found_b | full | overlap;
          win_row     <= found_a ? row_a : (found_b ? row_b : '0);
          win_col     <= found_a ? col_a : (found_b ? col_b : '0);
          win_dir     <= found_a ? dir_a : (found_b ? dir_b : DIR_H);
          valid       <= 1'b1;
          busy        <= 1'b0;
        end
        default: busy <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_line_judge.sv
// Directed scoreboard bench for line_judge on a 3x3/3 board and a 15x15/5 board.
module tb_line_judge;

  typedef struct packed {
    logic       win_a;
    logic       win_b;
    logic       draw;
    logic       illegal;
    logic       eog;
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] dir;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         req3 = 1'b0;
  logic [8:0]   board_a3 = '0;
  logic [8:0]   board_b3 = '0;
  logic         ready3, valid3, eog3, win_a3, win_b3, draw3, illegal3;
  logic [1:0]   win_row3, win_col3, win_dir3;

  logic         req15 = 1'b0;
  logic [224:0] board_a15 = '0;
  logic [224:0] board_b15 = '0;
  logic         ready15, valid15, eog15, win_a15, win_b15, draw15, illegal15;
  logic [3:0]   win_row15, win_col15;
  logic [1:0]   win_dir15;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  line_judge #(.ROWS(3), .COLS(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .ready(ready3),
    .board_a(board_a3), .board_b(board_b3), .valid(valid3),
    .end_of_game(eog3), .win_a(win_a3), .win_b(win_b3), .draw(draw3),
    .illegal(illegal3), .win_row(win_row3), .win_col(win_col3), .win_dir(win_dir3)
  );

  line_judge #(.ROWS(15), .COLS(15), .WIN_LEN(5)) dut15 (
    .clk(clk), .reset(reset), .req(req15), .ready(ready15),
    .board_a(board_a15), .board_b(board_b15), .valid(valid15),
    .end_of_game(eog15), .win_a(win_a15), .win_b(win_b15), .draw(draw15),
    .illegal(illegal15), .win_row(win_row15), .win_col(win_col15), .win_dir(win_dir15)
  );

  function automatic exp_t mk(input logic wa, input logic wb, input logic dr, input logic il,
                              input logic eg, input int row, input int col, input int dir);
    exp_t e;
    e.win_a = wa; e.win_b = wb; e.draw = dr; e.illegal = il; e.eog = eg;
    e.row = 4'(row); e.col = 4'(col); e.dir = 2'(dir);
    return e;
  endfunction

  function automatic exp_t getResult(input bit big);
    exp_t g;
    if (big) begin
      g.win_a = win_a15; g.win_b = win_b15; g.draw = draw15; g.illegal = illegal15;
      g.eog = eog15; g.row = win_row15; g.col = win_col15; g.dir = win_dir15;
    end else begin
      g.win_a = win_a3; g.win_b = win_b3; g.draw = draw3; g.illegal = illegal3;
      g.eog = eog3; g.row = {2'b00, win_row3}; g.col = {2'b00, win_col3}; g.dir = win_dir3;
    end
    return g;
  endfunction

  task automatic checkOutput(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit big, input logic [224:0] a, input logic [224:0] b,
                               input exp_t e, input bit poke, input string tag);
    int   k;
    int   n;
    exp_t want;
    n = big ? 225 : 9;
    sb.push_back(e);
    @(negedge clk);
    if (big) begin
      board_a15 = a; board_b15 = b; req15 = 1'b1;
    end else begin
      board_a3 = a[8:0]; board_b3 = b[8:0]; req3 = 1'b1;
    end
    @(posedge clk);
    #1;
    req3 = 1'b0;
    req15 = 1'b0;
    board_a3 = ~board_a3; board_b3 = ~board_b3;
    board_a15 = ~board_a15; board_b15 = ~board_b15;
    checkOutput(32'(big ? ready15 : ready3), 32'd0, {tag, "_ready_low"});
    checkOutput(32'(getResult(big)), 32'd0, {tag, "_cleared"});
    k = 0;
    while (!(big ? valid15 : valid3) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
      req3 = (poke && k == 3) ? 1'b1 : 1'b0;
    end
    req3 = 1'b0;
    checkOutput(32'(k), 32'(n + 1), {tag, "_latency"});
    want = sb.pop_front();
    checkOutput(32'(getResult(big)), 32'(want), {tag, "_result"});
    @(posedge clk);
    #1;
    checkOutput(32'(big ? valid15 : valid3), 32'd0, {tag, "_pulse"});
    checkOutput(32'(getResult(big)), 32'(want), {tag, "_hold"});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [224:0] va;
    logic [224:0] vb;
    int           vseen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput(32'(getResult(1'b0)), 32'd0, "rst_outputs3");
    checkOutput(32'(getResult(1'b1)), 32'd0, "rst_outputs15");
    checkOutput(32'(valid3), 32'd0, "rst_valid3");
    checkOutput(32'(ready3), 32'd0, "rst_ready_busy");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(32'(ready3), 32'd1, "rst_ready_after");

    // 3x3 directed cases
    applyStimulus(1'b0, 225'(9'h007), 225'(9'h018), mk(1,0,0,0,1, 0,0,0), 1'b1, "row0_h");
    applyStimulus(1'b0, 225'(9'h111), 225'(9'h000), mk(1,0,0,0,1, 0,0,2), 1'b0, "diag_d");
    applyStimulus(1'b0, 225'(9'h054), 225'(9'h000), mk(1,0,0,0,1, 0,2,3), 1'b0, "anti_a");
    applyStimulus(1'b0, 225'(9'h0E6), 225'(9'h119), mk(0,1,0,0,1, 0,0,2), 1'b0, "full_b_diag");
    applyStimulus(1'b0, 225'(9'h18D), 225'(9'h072), mk(0,0,1,0,1, 0,0,0), 1'b0, "draw");
    applyStimulus(1'b0, 225'(9'h001), 225'(9'h001), mk(0,0,0,1,1, 0,0,0), 1'b0, "overlap");
    applyStimulus(1'b0, 225'(9'h007), 225'(9'h1C0), mk(1,1,0,1,1, 0,0,0), 1'b0, "both_win");
    applyStimulus(1'b0, 225'(9'h00E), 225'(9'h000), mk(0,0,0,0,0, 0,0,0), 1'b0, "row_wrap");

    // 15x15 gomoku cases
    va = '0; vb = '0;
    for (int i = 10; i < 15; i++) vb[i * 15 + 14] = 1'b1;
    applyStimulus(1'b1, va, vb, mk(0,1,0,0,1, 10,14,1), 1'b0, "g_vert_b");
    va = '0; vb = '0;
    for (int i = 0; i < 4; i++) va[3 * 15 + i] = 1'b1;
    applyStimulus(1'b1, va, vb, mk(0,0,0,0,0, 0,0,0), 1'b0, "g_four");
    va = '0; vb = '0;
    for (int i = 0; i < 5; i++) va[i * 15 + (14 - i)] = 1'b1;
    applyStimulus(1'b1, va, vb, mk(1,0,0,0,1, 0,14,3), 1'b0, "g_anti");

    // Reset in the middle of a scan
    @(negedge clk);
    board_a3 = 9'h007; board_b3 = 9'h000; req3 = 1'b1;
    @(posedge clk);
    #1;
    req3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput(32'(getResult(1'b0)), 32'd0, "abort_outputs");
    checkOutput(32'(valid3), 32'd0, "abort_valid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput(32'(ready3), 32'd0, "abort_ready_busy");
    @(posedge clk);
    #1;
    checkOutput(32'(ready3), 32'd1, "abort_ready_after");
    vseen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid3) vseen++;
    end
    checkOutput(32'(vseen), 32'd0, "abort_no_valid");
    checkOutput(32'(getResult(1'b0)), 32'd0, "abort_outputs_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
